spr_bus_arbiter_cappuccino: RTL

Sequences and shares the single SPR bus between two requesters. Requester one is the ctrl-stage mfspr/mtspr instruction. Requester two is the debug unit (DU). The block generates the mfspr/mtspr acks that release the ctrl-stage stall, and a DU ack. A timeout counter ensures an unresponsive SPR slave can never hang the pipeline.

---
 rtl/spr_bus_arbiter_cappuccino.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/spr_bus_arbiter_cappuccino.sv
// Shares the SPR bus between the ctrl-stage mfspr/mtspr and the debug unit.
// Generates the ctrl and DU acks; a timeout forces completion if no slave answers.
module spr_bus_arbiter_cappuccino #(
  parameter int unsigned OPTION_OPERAND_WIDTH  = 32,
  parameter int unsigned OPTION_SPR_ADDR_WIDTH = 16,
  parameter int unsigned OPTION_SPR_TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ctrl_op_mfspr_i,
  input  logic                             ctrl_op_mtspr_i,
  input  logic [OPTION_SPR_ADDR_WIDTH-1:0] ctrl_spr_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  ctrl_spr_wdata_i,
  input  logic                             padv_ctrl_i,
  input  logic                             pipeline_flush_i,
  output logic                             ctrl_mfspr_ack_o,
  output logic                             ctrl_mtspr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  ctrl_mfspr_dat_o,
  input  logic                             du_stb_i,
  input  logic                             du_we_i,
  input  logic [OPTION_SPR_ADDR_WIDTH-1:0] du_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  du_dat_i,
  input  logic                             du_stall_cpu_i,
  output logic                             du_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  du_dat_o,
  output logic                             spr_bus_stb_o,
  output logic                             spr_bus_we_o,
  output logic [OPTION_SPR_ADDR_WIDTH-1:0] spr_bus_addr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_o,
  input  logic                             spr_bus_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_i,
  output logic                             spr_timeout_o
);

  localparam int unsigned DW    = OPTION_OPERAND_WIDTH;
  localparam int unsigned AW    = OPTION_SPR_ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(OPTION_SPR_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPTION_SPR_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PIPE      = 2'd1,
    S_DU        = 2'd2,
    S_PIPE_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_stb;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_kill;
  logic             r_op_mf;
  logic             r_mfspr_ack;
  logic             r_mtspr_ack;
  logic [DW-1:0]    r_mfspr_dat;
  logic             r_du_ack;
  logic [DW-1:0]    r_du_dat;
  logic             r_timeout;

  state_t           w_state_nxt;
  logic             w_stb_nxt;
  logic             w_we_nxt;
  logic [AW-1:0]    w_addr_nxt;
  logic [DW-1:0]    w_wdata_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_kill_nxt;
  logic             w_op_mf_nxt;
  logic             w_mfspr_ack_nxt;
  logic             w_mtspr_ack_nxt;
  logic [DW-1:0]    w_mfspr_dat_nxt;
  logic             w_du_ack_nxt;
  logic [DW-1:0]    w_du_dat_nxt;
  logic             w_timeout_nxt;

  logic             w_pipe_req;
  logic             w_done;
  logic [DW-1:0]    w_rdata;

  // State and all outputs are registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_kill      <= 1'b0;
      r_op_mf     <= 1'b0;
      r_mfspr_ack <= 1'b0;
      r_mtspr_ack <= 1'b0;
      r_mfspr_dat <= '0;
      r_du_ack    <= 1'b0;
      r_du_dat    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stb       <= w_stb_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_kill      <= w_kill_nxt;
      r_op_mf     <= w_op_mf_nxt;
      r_mfspr_ack <= w_mfspr_ack_nxt;
      r_mtspr_ack <= w_mtspr_ack_nxt;
      r_mfspr_dat <= w_mfspr_dat_nxt;
      r_du_ack    <= w_du_ack_nxt;
      r_du_dat    <= w_du_dat_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Grant, completion and ack sequencing
  always_comb begin
    w_state_nxt     = r_state;
    w_stb_nxt       = r_stb;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_cnt_nxt       = r_cnt;
    w_kill_nxt      = r_kill;
    w_op_mf_nxt     = r_op_mf;
    w_mfspr_ack_nxt = r_mfspr_ack;
    w_mtspr_ack_nxt = r_mtspr_ack;
    w_mfspr_dat_nxt = r_mfspr_dat;
    w_du_ack_nxt    = 1'b0;
    w_du_dat_nxt    = r_du_dat;
    w_timeout_nxt   = 1'b0;

    w_pipe_req = (ctrl_op_mfspr_i | ctrl_op_mtspr_i) & ~pipeline_flush_i;
    // An ack in the limit cycle wins over the timeout
    w_done     = r_stb & (spr_bus_ack_i | (r_cnt == CNT_LAST));
    w_rdata    = spr_bus_ack_i ? spr_bus_dat_i : '0;

    case (r_state)
      S_IDLE: begin
        if (du_stb_i & du_stall_cpu_i) begin
          w_state_nxt = S_DU;
          w_stb_nxt   = 1'b1;
          w_we_nxt    = du_we_i;
          w_addr_nxt  = du_addr_i;
          w_wdata_nxt = du_dat_i;
          w_cnt_nxt   = '0;
        end else if (w_pipe_req) begin
          w_state_nxt = S_PIPE;
          w_stb_nxt   = 1'b1;
          w_we_nxt    = ctrl_op_mtspr_i;
          w_addr_nxt  = ctrl_spr_addr_i;
          w_wdata_nxt = ctrl_spr_wdata_i;
          w_cnt_nxt   = '0;
          w_kill_nxt  = 1'b0;
          w_op_mf_nxt = ~ctrl_op_mtspr_i;
        end else if (du_stb_i) begin
          w_state_nxt = S_DU;
          w_stb_nxt   = 1'b1;
          w_we_nxt    = du_we_i;
          w_addr_nxt  = du_addr_i;
          w_wdata_nxt = du_dat_i;
          w_cnt_nxt   = '0;
        end
      end

      S_PIPE: begin
        if (pipeline_flush_i) begin
          w_kill_nxt = 1'b1;
        end
        if (w_done) begin
          w_stb_nxt       = 1'b0;
          w_timeout_nxt   = ~spr_bus_ack_i;
          w_mfspr_dat_nxt = w_rdata;
          // A flushed instruction finishes its bus access but gets no ack
          if (r_kill | pipeline_flush_i) begin
            w_state_nxt = S_IDLE;
            w_kill_nxt  = 1'b0;
          end else begin
            w_state_nxt     = S_PIPE_DONE;
            w_mfspr_ack_nxt = r_op_mf;
            w_mtspr_ack_nxt = ~r_op_mf;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_DU: begin
        if (w_done) begin
          w_stb_nxt     = 1'b0;
          w_timeout_nxt = ~spr_bus_ack_i;
          w_du_dat_nxt  = w_rdata;
          w_du_ack_nxt  = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_PIPE_DONE: begin
        // Hold the ack until the instruction leaves ctrl so it is not reissued
        if (padv_ctrl_i | pipeline_flush_i) begin
          w_state_nxt     = S_IDLE;
          w_mfspr_ack_nxt = 1'b0;
          w_mtspr_ack_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_stb_nxt   = 1'b0;
      end
    endcase
  end

  assign ctrl_mfspr_ack_o = r_mfspr_ack;
  assign ctrl_mtspr_ack_o = r_mtspr_ack;
  assign ctrl_mfspr_dat_o = r_mfspr_dat;
  assign du_ack_o         = r_du_ack;
  assign du_dat_o         = r_du_dat;
  assign spr_bus_stb_o    = r_stb;
  assign spr_bus_we_o     = r_we;
  assign spr_bus_addr_o   = r_addr;
  assign spr_bus_dat_o    = r_wdata;
  assign spr_timeout_o    = r_timeout;

endmodule
